// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter and its grant logic.
// Holds FSM encoding, the latched-command layout at default widths and arbitration mode codes.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_LINE_W = 64;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  rw;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_LINE_W-1:0] wdata;
  } arb_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant picker: round-robin from rr_ptr_i+1 (mod NUM_CH) or fixed, ch0 highest.
// Zero latency; no state, the pointer register lives in the parent.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int FIXED_PRI = ARB_RR,
  localparam int PTR_W     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [PTR_W-1:0]  rr_ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [PTR_W-1:0]  gnt_idx_o,
  output logic              gnt_vld_o
);

  logic [PTR_W-1:0] idx;

  // Loops run from the least preferred candidate down so the most preferred one wins last.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = '0;
    if (FIXED_PRI == ARB_FIXED) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          gnt_idx_o = PTR_W'(i);
          gnt_vld_o = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        idx = PTR_W'((int'(rr_ptr_i) + k) % NUM_CH);
        if (req_i[idx]) begin
          gnt_idx_o = idx;
          gnt_vld_o = 1'b1;
        end
      end
    end
    if (gnt_vld_o) begin
      gnt_o = NUM_CH'(1) << gnt_idx_o;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates NUM_CH cache requesters onto one unified-memory port, one access outstanding.
// Ack in IDLE, mem strobes from the next cycle, response one cycle after mem_rdy or timeout.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int LINE_W    = 64,
  parameter int NUM_CH    = 2,
  parameter int FIXED_PRI = ARB_RR,
  parameter int TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_rw,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*LINE_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ack,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [LINE_W-1:0]        resp_rdata,
  output logic                     resp_err,
  output logic                     busy,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_rdy
);

  localparam int               PTR_W    = $clog2(NUM_CH);
  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic              cmd_rw_q, cmd_rw_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LINE_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [NUM_CH-1:0] resp_valid_q, resp_valid_d;
  logic [LINE_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [NUM_CH-1:0] gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;

  rr_arbiter #(
    .NUM_CH    (NUM_CH),
    .FIXED_PRI (FIXED_PRI)
  ) u_arb (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_rw    = req_rw[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  // rr_ptr doubles as the owner of the outstanding access, so the response is steered by it.
  always_comb begin
    state_d      = state_q;
    cmd_rw_d     = cmd_rw_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    mem_re_d     = mem_re_q;
    mem_we_d     = mem_we_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          cmd_rw_d    = sel_rw;
          cmd_addr_d  = sel_addr;
          cmd_wdata_d = sel_wdata;
          rr_ptr_d    = gnt_idx;
          cnt_d       = '0;
          mem_re_d    = ~sel_rw;
          mem_we_d    = sel_rw;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rdy || (cnt_q == CNT_LAST)) begin
          resp_valid_d = NUM_CH'(1) << rr_ptr_q;
          resp_err_d   = ~mem_rdy;
          resp_rdata_d = (mem_rdy && !cmd_rw_q) ? mem_rdata : '0;
          mem_re_d     = 1'b0;
          mem_we_d     = 1'b0;
          state_d      = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_rw_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      rr_ptr_q     <= PTR_W'(NUM_CH - 1);
      cnt_q        <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_rw_q     <= cmd_rw_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ack    = (state_q == IDLE) ? gnt : '0;
  assign busy       = (state_q != IDLE);
  assign mem_addr   = cmd_addr_q;
  assign mem_wdata  = cmd_wdata_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: 2-ch round-robin, 2-ch fixed and 3-ch round-robin instances.
// Transaction-level model predicts grants, strobes, response timing and data.
module tb_unified_mem_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   req_valid, req_rw;
  logic [47:0]  req_addr;
  logic [191:0] req_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_rdy;
  int           dut_sel;

  logic [1:0] rv_a, rv_b, ack_a, ack_b, rsv_a, rsv_b;
  logic [2:0] rv_c, ack_c, rsv_c;
  logic [63:0] rd_a, rd_b, rd_c, wd_a, wd_b, wd_c;
  logic [15:0] ma_a, ma_b, ma_c;
  logic er_a, er_b, er_c, bz_a, bz_b, bz_c, re_a, re_b, re_c, we_a, we_b, we_c;

  assign rv_a = (dut_sel == 0) ? req_valid[1:0] : 2'b00;
  assign rv_b = (dut_sel == 1) ? req_valid[1:0] : 2'b00;
  assign rv_c = (dut_sel == 2) ? req_valid : 3'b000;

  unified_mem_arbiter #(.ADDR_W(16), .LINE_W(64), .NUM_CH(2), .FIXED_PRI(0), .TIMEOUT(TO)) u_rr2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_a), .req_rw(req_rw[1:0]), .req_addr(req_addr[31:0]),
    .req_wdata(req_wdata[127:0]), .req_ack(ack_a), .resp_valid(rsv_a), .resp_rdata(rd_a),
    .resp_err(er_a), .busy(bz_a), .mem_addr(ma_a), .mem_re(re_a), .mem_we(we_a),
    .mem_wdata(wd_a), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy));

  unified_mem_arbiter #(.ADDR_W(16), .LINE_W(64), .NUM_CH(2), .FIXED_PRI(1), .TIMEOUT(TO)) u_fx2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_b), .req_rw(req_rw[1:0]), .req_addr(req_addr[31:0]),
    .req_wdata(req_wdata[127:0]), .req_ack(ack_b), .resp_valid(rsv_b), .resp_rdata(rd_b),
    .resp_err(er_b), .busy(bz_b), .mem_addr(ma_b), .mem_re(re_b), .mem_we(we_b),
    .mem_wdata(wd_b), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy));

  unified_mem_arbiter #(.ADDR_W(16), .LINE_W(64), .NUM_CH(3), .FIXED_PRI(0), .TIMEOUT(TO)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_c), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ack(ack_c), .resp_valid(rsv_c), .resp_rdata(rd_c),
    .resp_err(er_c), .busy(bz_c), .mem_addr(ma_c), .mem_re(re_c), .mem_we(we_c),
    .mem_wdata(wd_c), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy));

  logic [2:0]  o_ack, o_rv;
  logic [63:0] o_rd, o_wd;
  logic [15:0] o_ma;
  logic        o_er, o_bz, o_re, o_we;

  always_comb begin
    case (dut_sel)
      1: begin
        o_ack = {1'b0, ack_b}; o_rv = {1'b0, rsv_b}; o_rd = rd_b; o_wd = wd_b;
        o_ma = ma_b; o_er = er_b; o_bz = bz_b; o_re = re_b; o_we = we_b;
      end
      2: begin
        o_ack = ack_c; o_rv = rsv_c; o_rd = rd_c; o_wd = wd_c;
        o_ma = ma_c; o_er = er_c; o_bz = bz_c; o_re = re_c; o_we = we_c;
      end
      default: begin
        o_ack = {1'b0, ack_a}; o_rv = {1'b0, rsv_a}; o_rd = rd_a; o_wd = wd_a;
        o_ma = ma_a; o_er = er_a; o_bz = bz_a; o_re = re_a; o_we = we_a;
      end
    endcase
  end

  // Requester-side view: pending flag and payload per channel.
  bit          pend [3];
  bit          p_rw [3];
  logic [15:0] p_addr [3];
  logic [63:0] p_wd [3];
  int          nch;
  bit          fixed;
  int          last_g;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 3; i++) begin
      req_valid[i]            = pend[i];
      req_rw[i]               = p_rw[i];
      req_addr[i*16 +: 16]    = p_addr[i];
      req_wdata[i*64 +: 64]   = p_wd[i];
    end
  endtask

  task automatic set_req(input int ch, input bit rw, input logic [15:0] a, input logic [63:0] wd);
    pend[ch]   = 1'b1;
    p_rw[ch]   = rw;
    p_addr[ch] = a;
    p_wd[ch]   = wd;
  endtask

  function automatic int exp_grant();
    if (fixed) begin
      for (int i = 0; i < nch; i++) if (pend[i]) return i;
    end else begin
      for (int k = 1; k <= nch; k++) if (pend[(last_g + k) % nch]) return (last_g + k) % nch;
    end
    return -1;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, " ack"}, 64'(o_ack), 64'd0);
    chk({tag, " rv"}, 64'(o_rv), 64'd0);
    chk({tag, " rdata"}, o_rd, 64'd0);
    chk({tag, " err"}, 64'(o_er), 64'd0);
    chk({tag, " busy"}, 64'(o_bz), 64'd0);
    chk({tag, " addr"}, 64'(o_ma), 64'd0);
    chk({tag, " re"}, 64'(o_re), 64'd0);
    chk({tag, " we"}, 64'(o_we), 64'd0);
    chk({tag, " wdata"}, o_wd, 64'd0);
  endtask

  task automatic do_reset(input int sel);
    dut_sel = sel;
    nch     = (sel == 2) ? 3 : 2;
    fixed   = (sel == 1);
    last_g  = nch - 1;
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    drive_reqs();
    mem_rdy = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk_quiet("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // lat in 1..TO: mem_rdy raised in that access cycle; anything else runs into the timeout.
  task automatic access(input int lat, input logic [63:0] rd_val, input string tag);
    int g, n;
    bit rw, err;
    logic [15:0] a;
    logic [63:0] wd, cap;
    drive_reqs();
    g = exp_grant();
    @(negedge clk);
    if (g < 0) begin
      chk({tag, " idle ack"}, 64'(o_ack), 64'd0);
      chk({tag, " idle busy"}, 64'(o_bz), 64'd0);
      tick();
      return;
    end
    chk({tag, " ack"}, 64'(o_ack), 64'(1 << g));
    chk({tag, " busy0"}, 64'(o_bz), 64'd0);
    rw = p_rw[g]; a = p_addr[g]; wd = p_wd[g];
    pend[g] = 1'b0;
    last_g  = g;
    n   = (lat >= 1 && lat <= TO) ? lat : TO;
    err = (n != lat);
    cap = '0;
    for (int c = 1; c <= n; c++) begin
      tick();
      drive_reqs();
      mem_rdy   = (c == lat);
      mem_rdata = (c == lat) ? rd_val : {$urandom, $urandom};
      if (c == lat) cap = rd_val;
      @(negedge clk);
      chk({tag, " re"}, 64'(o_re), 64'(!rw));
      chk({tag, " we"}, 64'(o_we), 64'(rw));
      chk({tag, " addr"}, 64'(o_ma), 64'(a));
      chk({tag, " wdata"}, o_wd, wd);
      chk({tag, " ack busy"}, 64'(o_ack), 64'd0);
      chk({tag, " early rv"}, 64'(o_rv), 64'd0);
    end
    tick();
    mem_rdy   = 1'b0;
    mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    chk({tag, " resp_valid"}, 64'(o_rv), 64'(1 << g));
    chk({tag, " resp_rdata"}, o_rd, (rw || err) ? 64'd0 : cap);
    chk({tag, " resp_err"}, 64'(o_er), 64'(err));
    chk({tag, " resp re/we"}, 64'({o_re, o_we}), 64'd0);
    chk({tag, " resp ack"}, 64'(o_ack), 64'd0);
    chk({tag, " resp busy"}, 64'(o_bz), 64'd1);
    tick();
  endtask

  task automatic random_phase(input int sel, input int n_acc);
    int lat;
    do_reset(sel);
    for (int k = 0; k < n_acc; k++) begin
      for (int i = 0; i < nch; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 60)
          set_req(i, 1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom});
        else if (pend[i] && $urandom_range(0, 99) < 10)
          pend[i] = 1'b0;
      end
      lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(1, 6));
      access(lat, {$urandom, $urandom}, "rnd");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_rdata = '0;
    req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0; p_rw[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0;
    end

    // Reset in the middle of an access: everything clears, no late response.
    do_reset(0);
    set_req(0, 1'b0, 16'h0040, 64'd0);
    drive_reqs();
    @(negedge clk);
    chk("pre-rst ack", 64'(o_ack), 64'd1);
    tick();
    pend[0] = 1'b0;
    drive_reqs();
    tick();
    @(negedge clk);
    chk("pre-rst re", 64'(o_re), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("mid-rst");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    last_g = 1;
    for (int i = 0; i < 5; i++) begin
      mem_rdy = 1'b1;
      @(negedge clk);
      chk("post-rst rv", 64'(o_rv), 64'd0);
      chk("post-rst busy", 64'(o_bz), 64'd0);
      tick();
    end
    mem_rdy = 1'b0;

    set_req(0, 1'b0, 16'h0040, 64'd0);
    access(4, 64'hDEAD_BEEF_0123_4567, "rd0");

    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++) if (!pend[i]) set_req(i, 1'b0, 16'(16'h0100 + k * 2 + i), 64'd0);
      access(2, {$urandom, $urandom}, "rr");
    end

    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++) if (!pend[i]) set_req(i, 1'b0, 16'(16'h0200 + k * 2 + i), 64'd0);
      access(3, {$urandom, $urandom}, "fix");
    end
    access(2, {$urandom, $urandom}, "fix starve");

    do_reset(0);
    set_req(1, 1'b1, 16'h1234, 64'h1111_2222_3333_4444);
    access(3, {$urandom, $urandom}, "wr");
    set_req(0, 1'b0, 16'h0ABC, 64'd0);
    access(0, {$urandom, $urandom}, "timeout");
    set_req(1, 1'b0, 16'h0DEF, 64'd0);
    access(2, 64'h0123_4567_89AB_CDEF, "after to");
    set_req(0, 1'b0, 16'h0F00, 64'd0);
    access(TO, 64'hCAFE_F00D_5555_AAAA, "rdy at last");

    do_reset(2);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) if (!pend[i]) set_req(i, 1'(k), 16'(16'h0300 + k * 3 + i), {$urandom, $urandom});
      access(1, {$urandom, $urandom}, "rr3");
    end

    random_phase(0, 60);
    random_phase(1, 40);
    random_phase(2, 60);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
